grid_frame_rx: RTL and testbench
================================

// Module: grid_frame_rx
// PURPOSE
//  Downstream consumer of the grid-coordinate UART frame stream. Takes bytes from a uart_rx
//  (clk_a domain, 115200 8N1) and parses 11-byte frames C0 C0 06 01 B9 XH XL YH YL 01 CF.
//  Emits the decoded 16-bit x/y grid coordinates with a one-cycle valid pulse, plus error and
//  frame-count status. Sits between uart_rx and the LVDS/display logic.
// PARAMETERS
//  EXP_ADDR     8'h01    address byte accepted (frame byte 3)
//  EXP_CMD      8'hB9    command byte accepted (frame byte 4)
//  TIMEOUT_CYC  21_700   max clk_a cycles between bytes mid-frame (~10 byte times @25MHz); timeout build only
// PORTS
//  clk_a          in   1   system clock, 25 MHz
//  rst_n          in   1   asynchronous active-low reset
//  i_data         in   8   received byte from uart_rx
//  i_valid        in   1   one-cycle strobe, i_data valid
//  o_x_grid       out  16  last good x coordinate, {XH,XL}
//  o_y_grid       out  16  last good y coordinate, {YH,YL}
//  o_frame_valid  out  1   one-cycle pulse, new x/y latched
//  o_frame_err    out  1   one-cycle pulse, frame rejected
//  o_frame_cnt    out  16  count of good frames, wraps FFFF->0000
//  o_busy         out  1   high while state != S_SYNC0
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, state S_SYNC0, payload counter 0.
//  - Only cycles with i_valid=1 advance the FSM; i_data is ignored otherwise. No backpressure.
//  - States/expected byte: S_SYNC0 C0 -> S_SYNC1 C0 -> S_LEN 06 -> S_ADDR EXP_ADDR
//    -> S_CMD EXP_CMD -> S_PAYLOAD (4 bytes, any value, 2-bit counter) -> S_FLAG 01 -> S_TAIL CF.
//  - Match: advance. S_PAYLOAD stays for 4 bytes, shifting in XH,XL,YH,YL (MSB first) to shadow regs.
//  - Mismatch in S_SYNC0: stay, no error (idle line noise).
//  - Mismatch in any other state: o_frame_err pulses; next state S_SYNC1 if byte==C0, else S_SYNC0.
//  - Exception: C0 received in S_LEN -> stay S_LEN, no error (tolerates C0 C0 C0 06 ...).
//  - Payload bytes never trigger resync, even if C0.
//  - Tail CF accepted in cycle N: in cycle N+1 o_x_grid/o_y_grid <= shadow, o_frame_valid=1,
//    o_frame_cnt += 1, state S_SYNC0. Latency tail-strobe -> valid = 1 cycle.
//  - Rejected frame: o_x_grid/o_y_grid/o_frame_cnt unchanged; shadow regs discarded.
//  - o_frame_valid and o_frame_err never both high in one cycle.
//  - Back-to-back frames (next C0 on cycle after tail) are accepted without loss.
//  - rst_n asserted mid-frame: partial frame dropped, no pulses, outputs to 0.
// CONFIGURATION
//  GRID_RX_TIMEOUT_EN defined: gap counter clears on each i_valid, counts while state != S_SYNC0;
//    reaching TIMEOUT_CYC -> o_frame_err pulse, state S_SYNC0. A byte strobe in the same cycle
//    as expiry wins (counter clears, byte processed, no timeout).
//  Undefined: no counter, no timeout; FSM waits indefinitely mid-frame; TIMEOUT_CYC unused.
// STRUCTURE
//  grid_frame_pkg: SYNC_BYTE=8'hC0, LEN_BYTE=8'h06, FLAG_BYTE=8'h01, TAIL_BYTE=8'hCF,
//    FRAME_BYTES=11, PAYLOAD_BYTES=4, FSM state encoding localparams (4-bit, matches tx side).
//  One sub-module: byte_gap_timer (clear, enable, expire pulse), instantiated only under
//    GRID_RX_TIMEOUT_EN. uart_rx is instantiated by the parent, not inside this block.
// TESTING
//  1 Frame C0 C0 06 01 B9 00 05 00 07 01 CF -> one valid pulse, x=0005, y=0007, cnt=1, no err.
//  2 C0 C0 06 01 B8 ... (bad cmd) then good frame x=1234 y=ABCD -> one err pulse, then valid
//    x=1234 y=ABCD, cnt=1.
//  3 C0 C0 C0 06 01 B9 C0 C0 C0 C0 01 CF -> accepted, x=C0C0, y=C0C0, no err.
//  4 Tail byte CE instead of CF -> err pulse, outputs keep previous frame, cnt unchanged.
//  5 cnt preloaded by 65535 good frames, one more -> cnt=0000, valid pulses.
//  6 TIMEOUT_EN: stop after 5 bytes, idle TIMEOUT_CYC -> err pulse, busy=0; then full good frame
//    accepted. Also rst_n low mid-frame -> all outputs 0, no pulses.

Source files
------------

// File: rtl/grid_frame_pkg.sv
// rtl/grid_frame_pkg.sv - framing constants and FSM state encoding for the grid-coordinate frame receiver
package grid_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hC0;
    localparam logic [7:0] LEN_BYTE  = 8'h06;
    localparam logic [7:0] FLAG_BYTE = 8'h01;
    localparam logic [7:0] TAIL_BYTE = 8'hCF;

    localparam int FRAME_BYTES   = 11;
    localparam int PAYLOAD_BYTES = 4;

    // Encoding shared with the transmit side
    localparam logic [3:0] ST_SYNC0   = 4'd0;
    localparam logic [3:0] ST_SYNC1   = 4'd1;
    localparam logic [3:0] ST_LEN     = 4'd2;
    localparam logic [3:0] ST_ADDR    = 4'd3;
    localparam logic [3:0] ST_CMD     = 4'd4;
    localparam logic [3:0] ST_PAYLOAD = 4'd5;
    localparam logic [3:0] ST_FLAG    = 4'd6;
    localparam logic [3:0] ST_TAIL    = 4'd7;

    typedef enum logic [3:0] {
        S_SYNC0   = ST_SYNC0,
        S_SYNC1   = ST_SYNC1,
        S_LEN     = ST_LEN,
        S_ADDR    = ST_ADDR,
        S_CMD     = ST_CMD,
        S_PAYLOAD = ST_PAYLOAD,
        S_FLAG    = ST_FLAG,
        S_TAIL    = ST_TAIL
    } rx_state_t;

endpackage

// File: rtl/byte_gap_timer.sv
// rtl/byte_gap_timer.sv - inter-byte gap counter; expire pulses after LIMIT enabled cycles without a clear
module byte_gap_timer #(
    parameter int LIMIT = 21_700
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    // A clear in the expiry cycle suppresses the pulse
    assign expire = enable && !clear && (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (!expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/grid_frame_rx.sv
// rtl/grid_frame_rx.sv - parses C0 C0 06 ADDR CMD XH XL YH YL 01 CF frames into x/y grid coordinates
// Optional inter-byte timeout enabled by defining GRID_RX_TIMEOUT_EN.
module grid_frame_rx
    import grid_frame_pkg::*;
#(
    parameter logic [7:0] EXP_ADDR = 8'h01,
    parameter logic [7:0] EXP_CMD  = 8'hB9
`ifdef GRID_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 21_700
`endif
) (
    input  logic        clk_a,
    input  logic        rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic [15:0] o_x_grid,
    output logic [15:0] o_y_grid,
    output logic        o_frame_valid,
    output logic        o_frame_err,
    output logic [15:0] o_frame_cnt,
    output logic        o_busy
);

    rx_state_t   state, state_next;
    logic [1:0]  pay_cnt, pay_cnt_next;
    logic [31:0] shadow;
    logic        shift_en;
    logic        done_next;
    logic        err_next;
    logic        gap_expire;

`ifdef GRID_RX_TIMEOUT_EN
    byte_gap_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk_a),
        .rst_n  (rst_n),
        .clear  (i_valid),
        .enable (state != S_SYNC0),
        .expire (gap_expire)
    );
`else
    assign gap_expire = 1'b0;
`endif

    assign o_busy = (state != S_SYNC0);

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_SYNC0;
            pay_cnt <= '0;
        end else begin
            state   <= state_next;
            pay_cnt <= pay_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        pay_cnt_next = pay_cnt;
        shift_en     = 1'b0;
        done_next    = 1'b0;
        err_next     = 1'b0;
        if (i_valid) begin
            unique case (state)
                S_SYNC0: begin
                    if (i_data == SYNC_BYTE) state_next = S_SYNC1;
                end
                S_SYNC1: begin
                    if (i_data == SYNC_BYTE) state_next = S_LEN;
                    else                     err_next   = 1'b1;
                end
                S_LEN: begin
                    // Extra leading sync bytes are tolerated here
                    if (i_data == LEN_BYTE)       state_next = S_ADDR;
                    else if (i_data != SYNC_BYTE) err_next   = 1'b1;
                end
                S_ADDR: begin
                    if (i_data == EXP_ADDR) state_next = S_CMD;
                    else                    err_next   = 1'b1;
                end
                S_CMD: begin
                    if (i_data == EXP_CMD) begin
                        state_next   = S_PAYLOAD;
                        pay_cnt_next = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    shift_en     = 1'b1;
                    pay_cnt_next = pay_cnt + 1'b1;
                    if (pay_cnt == 2'(PAYLOAD_BYTES - 1)) state_next = S_FLAG;
                end
                S_FLAG: begin
                    if (i_data == FLAG_BYTE) state_next = S_TAIL;
                    else                     err_next   = 1'b1;
                end
                S_TAIL: begin
                    if (i_data == TAIL_BYTE) begin
                        done_next  = 1'b1;
                        state_next = S_SYNC0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: state_next = S_SYNC0;
            endcase
            // A rejected byte that is itself a sync byte starts the next frame
            if (err_next) state_next = (i_data == SYNC_BYTE) ? S_SYNC1 : S_SYNC0;
        end else if (gap_expire) begin
            err_next   = 1'b1;
            state_next = S_SYNC0;
        end
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            shadow        <= '0;
            o_x_grid      <= '0;
            o_y_grid      <= '0;
            o_frame_cnt   <= '0;
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            o_frame_valid <= done_next;
            o_frame_err   <= err_next;
            if (shift_en) shadow <= {shadow[23:0], i_data};
            if (done_next) begin
                o_x_grid    <= shadow[31:16];
                o_y_grid    <= shadow[15:0];
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_grid_frame_rx.sv
// tb/tb_grid_frame_rx.sv - directed self-checking bench for grid_frame_rx
`timescale 1ns/1ps
module tb_grid_frame_rx;

    localparam int TIMEOUT_CYC = 21_700;

    logic        clk_a = 1'b0;
    logic        rst_n;
    logic [7:0]  i_data;
    logic        i_valid;
    logic [15:0] o_x_grid;
    logic [15:0] o_y_grid;
    logic        o_frame_valid;
    logic        o_frame_err;
    logic [15:0] o_frame_cnt;
    logic        o_busy;

    int n_vec  = 0;
    int n_err  = 0;
    int n_valid_p = 0;
    int n_err_p   = 0;
    int n_both    = 0;
    int v0, e0;

    grid_frame_rx dut (
        .clk_a         (clk_a),
        .rst_n         (rst_n),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_x_grid      (o_x_grid),
        .o_y_grid      (o_y_grid),
        .o_frame_valid (o_frame_valid),
        .o_frame_err   (o_frame_err),
        .o_frame_cnt   (o_frame_cnt),
        .o_busy        (o_busy)
    );

    always #20 clk_a = ~clk_a;

    always @(negedge clk_a) begin
        if (o_frame_valid) n_valid_p++;
        if (o_frame_err)   n_err_p++;
        if (o_frame_valid && o_frame_err) n_both++;
    end

`define CHECK(tag, obs, exp) \
    begin \
        n_vec++; \
        assert ((obs) === (exp)) else begin \
            n_err++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

    // Called at posedge+1; leaves i_valid high so consecutive calls are back-to-back
    task automatic put(input logic [7:0] b);
        i_data  = b;
        i_valid = 1'b1;
        @(posedge clk_a);
        #1;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(posedge clk_a);
            #1;
        end
    endtask

    task automatic frame(input logic [15:0] x, input logic [15:0] y,
                         input logic [7:0] cmd, input logic [7:0] tail);
        put(8'hC0); put(8'hC0); put(8'h06); put(8'h01); put(cmd);
        put(x[15:8]); put(x[7:0]); put(y[15:8]); put(y[7:0]);
        put(8'h01); put(tail);
    endtask

    task automatic mark();
        v0 = n_valid_p;
        e0 = n_err_p;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        repeat (3) @(posedge clk_a);
        #1;
        `CHECK("reset_x",     o_x_grid,      16'h0000)
        `CHECK("reset_y",     o_y_grid,      16'h0000)
        `CHECK("reset_cnt",   o_frame_cnt,   16'h0000)
        `CHECK("reset_flags", {o_frame_valid, o_frame_err, o_busy}, 3'b000)
        rst_n = 1'b1;
        idle(2);

        // Basic frame
        mark();
        frame(16'h0005, 16'h0007, 8'hB9, 8'hCF);
        `CHECK("f1_valid", o_frame_valid, 1'b1)
        `CHECK("f1_x",     o_x_grid,      16'h0005)
        `CHECK("f1_y",     o_y_grid,      16'h0007)
        `CHECK("f1_cnt",   o_frame_cnt,   16'h0001)
        `CHECK("f1_busy",  o_busy,        1'b0)
        idle(2);
        `CHECK("f1_vpulses", n_valid_p - v0, 1)
        `CHECK("f1_epulses", n_err_p - e0,   0)

        // Bad command, then good frame
        mark();
        put(8'hC0); put(8'hC0); put(8'h06); put(8'h01); put(8'hB8);
        `CHECK("f2_err", o_frame_err, 1'b1)
        `CHECK("f2_x_kept", o_x_grid, 16'h0005)
        idle(2);
        `CHECK("f2_busy", o_busy, 1'b0)
        frame(16'h1234, 16'hABCD, 8'hB9, 8'hCF);
        `CHECK("f2_xy",  {o_x_grid, o_y_grid}, 32'h1234ABCD)
        `CHECK("f2_cnt", o_frame_cnt, 16'h0002)
        idle(2);
        `CHECK("f2_pulses", {n_valid_p - v0, n_err_p - e0}, {32'd1, 32'd1})

        // Triple sync lead-in, C0 payload
        mark();
        put(8'hC0); put(8'hC0); put(8'hC0); put(8'h06); put(8'h01); put(8'hB9);
        put(8'hC0); put(8'hC0); put(8'hC0); put(8'hC0); put(8'h01); put(8'hCF);
        `CHECK("f3_xy",  {o_x_grid, o_y_grid}, 32'hC0C0C0C0)
        `CHECK("f3_cnt", o_frame_cnt, 16'h0003)
        idle(2);
        `CHECK("f3_pulses", {n_valid_p - v0, n_err_p - e0}, {32'd1, 32'd0})

        // Bad tail: outputs hold
        mark();
        frame(16'h1111, 16'h2222, 8'hB9, 8'hCE);
        `CHECK("f4_err", o_frame_err, 1'b1)
        idle(2);
        `CHECK("f4_xy",  {o_x_grid, o_y_grid}, 32'hC0C0C0C0)
        `CHECK("f4_cnt", o_frame_cnt, 16'h0003)
        `CHECK("f4_pulses", {n_valid_p - v0, n_err_p - e0}, {32'd0, 32'd1})

        // Back-to-back frames
        mark();
        frame(16'h0001, 16'h0002, 8'hB9, 8'hCF);
        `CHECK("b2b_first",  {o_frame_valid, o_x_grid, o_y_grid}, {1'b1, 32'h00010002})
        frame(16'h0003, 16'h0004, 8'hB9, 8'hCF);
        `CHECK("b2b_second", {o_frame_valid, o_x_grid, o_y_grid}, {1'b1, 32'h00030004})
        `CHECK("b2b_cnt", o_frame_cnt, 16'h0005)
        idle(2);
        `CHECK("b2b_pulses", {n_valid_p - v0, n_err_p - e0}, {32'd2, 32'd0})

        // Sync byte in address slot resyncs into the following frame
        mark();
        put(8'hC0); put(8'hC0); put(8'h06);
        put(8'hC0);
        `CHECK("rs_err", o_frame_err, 1'b1)
        put(8'hC0); put(8'h06); put(8'h01); put(8'hB9);
        put(8'h00); put(8'hAA); put(8'h00); put(8'hBB); put(8'h01); put(8'hCF);
        `CHECK("rs_xy",  {o_x_grid, o_y_grid}, 32'h00AA00BB)
        `CHECK("rs_cnt", o_frame_cnt, 16'h0006)
        idle(2);
        `CHECK("rs_pulses", {n_valid_p - v0, n_err_p - e0}, {32'd1, 32'd1})

        // Idle-line noise is silent
        mark();
        put(8'h55); put(8'hAA); put(8'h06); put(8'hCF);
        idle(2);
        `CHECK("noise", {o_busy, n_valid_p - v0, n_err_p - e0}, {1'b0, 32'd0, 32'd0})

        // Counter wrap
        force dut.o_frame_cnt = 16'hFFFF;
        #2;
        release dut.o_frame_cnt;
        idle(1);
        frame(16'h0102, 16'h0304, 8'hB9, 8'hCF);
        `CHECK("wrap_cnt",   o_frame_cnt,   16'h0000)
        `CHECK("wrap_valid", o_frame_valid, 1'b1)
        `CHECK("wrap_xy",    {o_x_grid, o_y_grid}, 32'h01020304)
        idle(2);

        // Reset mid-frame
        mark();
        put(8'hC0); put(8'hC0); put(8'h06); put(8'h01); put(8'hB9); put(8'h12);
        idle(1);
        `CHECK("mid_busy", o_busy, 1'b1)
        rst_n = 1'b0;
        #1;
        `CHECK("rst_outs", {o_x_grid, o_y_grid, o_frame_cnt, o_frame_valid, o_frame_err, o_busy}, 51'd0)
        idle(3);
        rst_n = 1'b1;
        idle(3);
        `CHECK("rst_pulses", {n_valid_p - v0, n_err_p - e0}, {32'd0, 32'd0})
        frame(16'hBEEF, 16'h0042, 8'hB9, 8'hCF);
        `CHECK("rst_after", {o_x_grid, o_y_grid, o_frame_cnt}, {32'hBEEF0042, 16'h0001})
        idle(2);

`ifdef GRID_RX_TIMEOUT_EN
        begin
            int k;
            bit seen;
            seen = 1'b0;
            mark();
            put(8'hC0); put(8'hC0); put(8'h06); put(8'h01); put(8'hB9);
            i_valid = 1'b0;
            for (k = 0; k < TIMEOUT_CYC + 50; k++) begin
                @(posedge clk_a);
                #1;
                if (o_frame_err) begin
                    seen = 1'b1;
                    break;
                end
            end
            `CHECK("to_seen", seen, 1'b1)
            `CHECK("to_window", (k >= TIMEOUT_CYC - 2) && (k <= TIMEOUT_CYC + 1), 1'b1)
            `CHECK("to_busy", o_busy, 1'b0)
            idle(2);
            frame(16'h7777, 16'h8888, 8'hB9, 8'hCF);
            `CHECK("to_after", {o_frame_valid, o_x_grid, o_y_grid, o_frame_cnt}, {1'b1, 32'h77778888, 16'h0002})
            idle(2);
        end
`endif

        `CHECK("never_both", n_both, 0)

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
